sar_adc_ctrl: RTL and testbench

Parametrised digital SAR conversion controller, successor to the fixed 8-bit SAR hard macro. It drives an external capacitive DAC and analog input mux, and reads a single comparator bit. Supports configurable resolution and channel count, plus single-channel or round-robin scan modes. Sits between the analog front-end (comparator/DAC/mux) and the digital sample consumer.

---
 rtl/sar_adc_ctrl_if.sv | 32 +++
 rtl/sar_adc_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sar_adc_ctrl_if.sv
// Bundle of signals between the SAR controller, the analog front-end
// (comparator, capacitive DAC, input mux) and the sample consumer.
// The master modport is the controller; the slave modport is its environment.
interface sar_adc_ctrl_if #(
  parameter int WIDTH = 10,
  parameter int NCH   = 4
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic            start;
  logic            mode;
  logic [CH_W-1:0] ch_sel;
  logic            cmp;
  logic            sample;
  logic [CH_W-1:0] ch_mux;
  logic [WIDTH-1:0] dac_code;
  logic            busy;
  logic [WIDTH-1:0] dout;
  logic [CH_W-1:0] dout_ch;
  logic            dout_valid;
  logic            eoc;

  modport master (
    input  start, mode, ch_sel, cmp,
    output sample, ch_mux, dac_code, busy, dout, dout_ch, dout_valid, eoc
  );

  modport slave (
    output start, mode, ch_sel, cmp,
    input  sample, ch_mux, dac_code, busy, dout, dout_ch, dout_valid, eoc
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Parametrised SAR conversion controller: track/hold, MSB-first binary
// search against an external comparator, single-channel or round-robin scan.
// Optional build macro SAR_ADC_AVG_EN: four conversions per channel averaged.
//
// Request semantics: start is a level sampled only while the FSM is IDLE;
// the edge that sees start=1 in IDLE accepts the request. While busy=1 start
// is ignored and nothing is queued. dout_valid and eoc are single-cycle
// pulses with no back-pressure; the consumer must take dout when they fire.
module sar_adc_ctrl #(
  parameter int WIDTH      = 10,
  parameter int NCH        = 4,
  parameter int SAMPLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  sar_adc_ctrl_if.master bus,
  output logic [1:0]  state_o
);
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_MAX = (WIDTH > SAMPLE_CYC) ? WIDTH : SAMPLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;     // sample-cycle count or bit step
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              mode_q, mode_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              sample_q, sample_d;
  logic [CH_W-1:0]   ch_mux_q, ch_mux_d;
  logic [WIDTH-1:0]  dac_q, dac_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [CH_W-1:0]   dout_ch_q, dout_ch_d;
  logic              dv_q, dv_d;
  logic              eoc_q, eoc_d;
  logic [WIDTH-1:0]  res_nx;
  logic [WIDTH-1:0]  result_val;
  logic              finish_ch;
  logic [CH_W-1:0]   ch_start;
`ifdef SAR_ADC_AVG_EN
  logic [1:0]        rep_q, rep_d;
  logic [WIDTH+1:0]  acc_q, acc_d;
  logic [WIDTH+1:0]  acc_sum;
`endif

  // One-hot trial bit for step k, MSB first.
  function automatic logic [WIDTH-1:0] trial_bit(input logic [CNT_W-1:0] k);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (CNT_W'(i) == k) m[WIDTH-1-i] = 1'b1;
    end
    return m;
  endfunction

  // Next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    mode_d     = mode_q;
    res_d      = res_q;
    sample_d   = 1'b0;
    ch_mux_d   = ch_mux_q;
    dac_d      = '0;
    busy_d     = 1'b0;
    dout_d     = dout_q;
    dout_ch_d  = dout_ch_q;
    dv_d       = 1'b0;
    eoc_d      = 1'b0;
    res_nx     = res_q;
    result_val = res_q;
    finish_ch  = 1'b0;
    ch_start   = (int'(bus.ch_sel) > NCH - 1) ? CH_W'(NCH - 1) : bus.ch_sel;
`ifdef SAR_ADC_AVG_EN
    rep_d      = rep_q;
    acc_d      = acc_q;
    acc_sum    = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d   = bus.mode;
          ch_d     = bus.mode ? '0 : ch_start;
          ch_mux_d = bus.mode ? '0 : ch_start;
          state_d  = SAMPLE;
          cnt_d    = '0;
          sample_d = 1'b1;
          busy_d   = 1'b1;
`ifdef SAR_ADC_AVG_EN
          rep_d    = '0;
          acc_d    = '0;
`endif
        end
      end
      SAMPLE: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(SAMPLE_CYC - 1)) begin
          state_d = CONVERT;
          cnt_d   = '0;
          res_d   = '0;
          dac_d   = trial_bit('0);
        end else begin
          cnt_d    = cnt_q + 1'b1;
          sample_d = 1'b1;
        end
      end
      CONVERT: begin
        busy_d = 1'b1;
        // The trial code currently on the DAC is kept only if vin >= it.
        res_nx = bus.cmp ? dac_q : res_q;
        res_d  = res_nx;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SAR_ADC_AVG_EN
          acc_sum = acc_q + {2'b00, res_nx};
          if (rep_q == 2'd3) begin
            finish_ch  = 1'b1;
            result_val = acc_sum[WIDTH+1:2];
          end else begin
            rep_d    = rep_q + 1'b1;
            acc_d    = acc_sum;
            state_d  = SAMPLE;
            cnt_d    = '0;
            sample_d = 1'b1;
          end
`else
          finish_ch  = 1'b1;
          result_val = res_nx;
`endif
          if (finish_ch) begin
            state_d   = DONE;
            dout_d    = result_val;
            dout_ch_d = ch_q;
            dv_d      = 1'b1;
            eoc_d     = !mode_q || (ch_q == CH_W'(NCH - 1));
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          dac_d = res_nx | trial_bit(CNT_W'(cnt_q + 1'b1));
        end
      end
      DONE: begin
        if (mode_q && (ch_q != CH_W'(NCH - 1))) begin
          ch_d     = ch_q + 1'b1;
          ch_mux_d = ch_q + 1'b1;
          state_d  = SAMPLE;
          cnt_d    = '0;
          sample_d = 1'b1;
          busy_d   = 1'b1;
`ifdef SAR_ADC_AVG_EN
          rep_d    = '0;
          acc_d    = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      mode_q    <= 1'b0;
      res_q     <= '0;
      sample_q  <= 1'b0;
      ch_mux_q  <= '0;
      dac_q     <= '0;
      busy_q    <= 1'b0;
      dout_q    <= '0;
      dout_ch_q <= '0;
      dv_q      <= 1'b0;
      eoc_q     <= 1'b0;
`ifdef SAR_ADC_AVG_EN
      rep_q     <= '0;
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      mode_q    <= mode_d;
      res_q     <= res_d;
      sample_q  <= sample_d;
      ch_mux_q  <= ch_mux_d;
      dac_q     <= dac_d;
      busy_q    <= busy_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      dv_q      <= dv_d;
      eoc_q     <= eoc_d;
`ifdef SAR_ADC_AVG_EN
      rep_q     <= rep_d;
      acc_q     <= acc_d;
`endif
    end
  end

  assign bus.sample     = sample_q;
  assign bus.ch_mux     = ch_mux_q;
  assign bus.dac_code   = dac_q;
  assign bus.busy       = busy_q;
  assign bus.dout       = dout_q;
  assign bus.dout_ch    = dout_ch_q;
  assign bus.dout_valid = dv_q;
  assign bus.eoc        = eoc_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl in its default build (WIDTH=10, NCH=4, SAMPLE_CYC=2).
// An ideal comparator returns vin >= dac_code for the channel on ch_mux.
module tb_sar_adc_ctrl;
  localparam int WIDTH = 10;
  localparam int NCH   = 4;
  localparam int CH_W  = 2;
  localparam int LAT   = 13;

  typedef struct {
    int               ch_sel;
    logic [WIDTH-1:0] vin;
    logic [WIDTH-1:0] exp_dout;
    logic [CH_W-1:0]  exp_ch;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  logic [WIDTH-1:0] ch_vin [NCH];
  logic [CH_W+WIDTH-1:0] exp_q[$];
  int total;
  int bad;
  int cyc;
  vec_t vecs [5];

  sar_adc_ctrl_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  sar_adc_ctrl #(.WIDTH(WIDTH), .NCH(NCH), .SAMPLE_CYC(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .state_o (state)
  );

  assign bus.cmp = (ch_vin[bus.ch_mux] >= bus.dac_code);

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every dout_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {20'd0, bus.dout_ch, bus.dout}, 32'hFFFF_FFFF);
      end else begin
        logic [CH_W+WIDTH-1:0] e;
        e = exp_q.pop_front();
        chk("sb_dout_ch", {30'd0, bus.dout_ch}, {30'd0, e[CH_W+WIDTH-1:WIDTH]});
        chk("sb_dout", {22'd0, bus.dout}, {22'd0, e[WIDTH-1:0]});
      end
    end
  end

  task automatic start_conv(input logic m, input int ch);
    bus.mode   = m;
    bus.ch_sel = CH_W'(ch);
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_valid();
    while (bus.dout_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("latency", cyc, LAT);
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < NCH; i++) ch_vin[i] = 10'h3C3;
    ch_vin[v.exp_ch] = v.vin;
    exp_q.push_back({v.exp_ch, v.exp_dout});
    start_conv(1'b0, v.ch_sel);
    chk("ch_mux", {30'd0, bus.ch_mux}, {30'd0, v.exp_ch});
    wait_valid();
    chk("eoc_single", {31'd0, bus.eoc}, 32'd1);
    tick();
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
    chk("dv_after", {31'd0, bus.dout_valid}, 32'd0);
    chk("dout_held", {22'd0, bus.dout}, {22'd0, v.exp_dout});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start  = 1'b0;
    bus.mode   = 1'b0;
    bus.ch_sel = '0;
    for (int i = 0; i < NCH; i++) ch_vin[i] = '0;
    vecs[0] = '{2, 10'h2A5, 10'h2A5, 2'd2};
    vecs[1] = '{0, 10'h3FF, 10'h3FF, 2'd0};
    vecs[2] = '{1, 10'h000, 10'h000, 2'd1};
    vecs[3] = '{7, 10'h155, 10'h155, 2'd3};
    vecs[4] = '{3, 10'h0F0, 10'h0F0, 2'd3};

    tick();
    tick();
    rst = 1'b0;
    chk("rst_sample", {31'd0, bus.sample}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_dac", {22'd0, bus.dac_code}, 32'd0);
    chk("rst_dout", {22'd0, bus.dout}, 32'd0);
    chk("rst_eoc", {31'd0, bus.eoc}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);

    // Detailed single conversion: sample window and first DAC trial codes.
    for (int i = 0; i < NCH; i++) ch_vin[i] = 10'h011;
    ch_vin[2] = 10'h2A5;
    exp_q.push_back({2'd2, 10'h2A5});
    start_conv(1'b0, 2);
    chk("c1_sample", {31'd0, bus.sample}, 32'd1);
    chk("c1_busy", {31'd0, bus.busy}, 32'd1);
    chk("c1_dac", {22'd0, bus.dac_code}, 32'd0);
    tick(); cyc++;
    chk("c2_sample", {31'd0, bus.sample}, 32'd1);
    tick(); cyc++;
    chk("c3_sample", {31'd0, bus.sample}, 32'd0);
    chk("c3_dac", {22'd0, bus.dac_code}, 32'h200);
    tick(); cyc++;
    chk("c4_dac", {22'd0, bus.dac_code}, 32'h300);
    tick(); cyc++;
    chk("c5_dac", {22'd0, bus.dac_code}, 32'h280);
    wait_valid();
    chk("c13_eoc", {31'd0, bus.eoc}, 32'd1);
    tick();
    chk("c14_busy", {31'd0, bus.busy}, 32'd0);
    // Start in the cycle right after eoc is accepted at once.
    exp_q.push_back({2'd2, 10'h2A5});
    start_conv(1'b0, 2);
    chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    chk("b2b_sample", {31'd0, bus.sample}, 32'd1);
    wait_valid();
    tick();

    // Table of single-mode vectors, including endpoints and ch_sel clamp.
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Scan of all channels with stray start pulses and input changes.
    ch_vin[0] = 10'h001;
    ch_vin[1] = 10'h155;
    ch_vin[2] = 10'h2AA;
    ch_vin[3] = 10'h3FE;
    exp_q.push_back({2'd0, 10'h001});
    exp_q.push_back({2'd1, 10'h155});
    exp_q.push_back({2'd2, 10'h2AA});
    exp_q.push_back({2'd3, 10'h3FE});
    start_conv(1'b1, 3);
    for (int c = 1; c <= 53; c++) begin
      chk($sformatf("scan_busy_%0d", c), {31'd0, bus.busy}, (c <= 52) ? 32'd1 : 32'd0);
      chk($sformatf("scan_dv_%0d", c), {31'd0, bus.dout_valid}, (c % 13 == 0 && c <= 52) ? 32'd1 : 32'd0);
      chk($sformatf("scan_eoc_%0d", c), {31'd0, bus.eoc}, (c == 52) ? 32'd1 : 32'd0);
      bus.start  = (c == 5 || c == 20) ? 1'b1 : 1'b0;
      bus.mode   = 1'b0;
      bus.ch_sel = 2'd1;
      tick();
    end
    bus.start = 1'b0;

    // Reset during CONVERT step 4 (cycle 7): everything back to reset values.
    for (int i = 0; i < NCH; i++) ch_vin[i] = 10'h155;
    start_conv(1'b0, 1);
    for (int c = 1; c < 7; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ra_sample", {31'd0, bus.sample}, 32'd0);
    chk("ra_ch_mux", {30'd0, bus.ch_mux}, 32'd0);
    chk("ra_dac", {22'd0, bus.dac_code}, 32'd0);
    chk("ra_busy", {31'd0, bus.busy}, 32'd0);
    chk("ra_dout", {22'd0, bus.dout}, 32'd0);
    chk("ra_dout_ch", {30'd0, bus.dout_ch}, 32'd0);
    chk("ra_dv", {31'd0, bus.dout_valid}, 32'd0);
    chk("ra_eoc", {31'd0, bus.eoc}, 32'd0);
    chk("ra_state", {30'd0, state}, 32'd0);
    for (int c = 0; c < 15; c++) tick();
    run_vec('{1, 10'h155, 10'h155, 2'd1});

    for (int c = 0; c < 5; c++) tick();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
